// File: rtl/pb_uart_tx_pkg.sv
// +------------------------------------------------------------------+
// | pb_uart_tx_pkg : register map, bit positions and FSM encoding     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pb_uart_tx_pkg;

  localparam logic [7:0] OFF_TXDATA  = 8'd0;
  localparam logic [7:0] OFF_STATUS  = 8'd1;
  localparam logic [7:0] OFF_CONTROL = 8'd2;
  localparam logic [7:0] OFF_DIV_LO  = 8'd3;
  localparam logic [7:0] OFF_DIV_HI  = 8'd4;
  localparam logic [7:0] NUM_REGS    = 8'd5;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_DONE  = 4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IRQ = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/pb_sync_fifo.sv
// +------------------------------------------------------------------+
// | pb_sync_fifo : single-clock FIFO with fall-through head           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_DEPTH);
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when the head leaves this cycle.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pb_uart_tx.sv
// +------------------------------------------------------------------+
// | pb_uart_tx : Picoblaze port-bus 8N1 UART transmitter with TX FIFO  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pb_uart_tx
  import pb_uart_tx_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDRESS = 8'h10,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          FIFO_AW      = 3,
  parameter logic [15:0] DEFAULT_DIV  = 16'd433
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] data_in,
  input  logic       read_strobe,
  input  logic       write_strobe,
  output logic [7:0] data_out,
  output logic       interrupt,
  output logic       tx
);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [1:0]  ctrl_q;
  logic [15:0] div_q;
  logic        ovf_q;
  logic        done_q;
  logic [7:0]  data_out_q;

  logic [7:0]  w_off;
  logic        w_hit;
  logic        w_wr_txdata, w_wr_status, w_wr_ctrl, w_wr_div_lo, w_wr_div_hi;
  logic        w_pop;
  logic        w_set_done;
  logic        w_bit_end;
  logic        w_busy;
  logic        w_tx_en;
  logic [7:0]  w_fifo_dout;
  logic        w_empty, w_full;
  logic [7:0]  w_rd_data;
  logic        w_unused;

  assign w_unused = read_strobe;

  assign w_off       = port_id - BASE_ADDRESS;
  assign w_hit       = (w_off < NUM_REGS);
  assign w_wr_txdata = write_strobe & w_hit & (w_off == OFF_TXDATA);
  assign w_wr_status = write_strobe & w_hit & (w_off == OFF_STATUS);
  assign w_wr_ctrl   = write_strobe & w_hit & (w_off == OFF_CONTROL);
  assign w_wr_div_lo = write_strobe & w_hit & (w_off == OFF_DIV_LO);
  assign w_wr_div_hi = write_strobe & w_hit & (w_off == OFF_DIV_HI);

  assign w_tx_en   = ctrl_q[CTRL_EN];
  assign w_busy    = (state_q != S_IDLE);
  assign w_bit_end = (baud_q == 16'd0);

  assign data_out  = data_out_q;
  assign interrupt = ctrl_q[CTRL_IRQ] & done_q;
  assign tx        = tx_q;

  pb_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_wr_txdata),
    .pop_i   (w_pop),
    .din_i   (data_in),
    .dout_o  (w_fifo_dout),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    w_pop      = 1'b0;
    w_set_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_tx_en && !w_empty) begin
          w_pop   = 1'b1;
          shift_d = w_fifo_dout;
          baud_d  = div_q;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          baud_d  = div_q;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          baud_d  = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit when more data waits.
          if (w_tx_en && !w_empty) begin
            w_pop   = 1'b1;
            shift_d = w_fifo_dout;
            baud_d  = div_q;
            state_d = S_START;
          end else begin
            w_set_done = w_empty;
            state_d    = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered and derived from the next state so it aligns with it.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    w_rd_data = 8'd0;
    if (w_hit) begin
      case (w_off)
        OFF_STATUS: begin
          w_rd_data[ST_EMPTY] = w_empty;
          w_rd_data[ST_FULL]  = w_full;
          w_rd_data[ST_BUSY]  = w_busy;
          w_rd_data[ST_OVF]   = ovf_q;
          w_rd_data[ST_DONE]  = done_q;
        end
        OFF_CONTROL: w_rd_data[1:0] = ctrl_q;
        OFF_DIV_LO:  w_rd_data      = div_q[7:0];
        OFF_DIV_HI:  w_rd_data      = div_q[15:8];
        default:     w_rd_data      = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 2'b00;
      div_q      <= DEFAULT_DIV;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= 8'd0;
    end else begin
      data_out_q <= w_rd_data;
      if (w_wr_ctrl) begin
        ctrl_q <= {data_in[CTRL_IRQ], data_in[CTRL_EN]};
      end
      if (w_wr_div_lo) begin
        div_q[7:0] <= data_in;
      end
      if (w_wr_div_hi) begin
        div_q[15:8] <= data_in;
      end
      if (w_wr_txdata && w_full && !w_pop) begin
        ovf_q <= 1'b1;
      end else if (w_wr_status && data_in[ST_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (w_set_done) begin
        done_q <= 1'b1;
      end else if ((w_wr_status && data_in[ST_DONE]) || w_wr_txdata) begin
        done_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pb_uart_tx.sv
// +------------------------------------------------------------------+
// | tb_pb_uart_tx : scoreboard bench, serial monitor decodes tx line  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pb_uart_tx;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic [7:0] data_in;
  logic       read_strobe;
  logic       write_strobe;
  logic [7:0] data_out;
  logic       interrupt;
  logic       tx;

  int total = 0;
  int bad = 0;
  int bit_clks = 434;
  int frames_done = 0;
  int cyc = 0;
  int frame_start[$];
  logic [7:0] sb[$];

  int         m_active = 0;
  int         m_i = 0;
  int         m_bit;
  int         m_ph;
  logic       m_lvl;
  logic       m_bad;
  logic [7:0] m_byte;
  logic [7:0] m_exp;

  pb_uart_tx #(
    .BASE_ADDRESS (8'h10),
    .FIFO_DEPTH   (8),
    .FIFO_AW      (3),
    .DEFAULT_DIV  (16'd433)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .data_in      (data_in),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .data_out     (data_out),
    .interrupt    (interrupt),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Serial monitor: decodes each 8N1 frame and compares against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      m_active = 0;
    end else begin
      if (m_active == 0 && tx === 1'b0) begin
        m_active = 1;
        m_i = 0;
        m_bad = 1'b0;
        m_byte = 8'h00;
        m_lvl = 1'b0;
        frame_start.push_back(cyc);
      end
      if (m_active != 0) begin
        m_bit = m_i / bit_clks;
        m_ph = m_i % bit_clks;
        if (m_bit == 0) begin
          if (tx !== 1'b0) m_bad = 1'b1;
        end else if (m_bit <= 8) begin
          if (m_ph == 0) begin
            m_lvl = tx;
            m_byte[m_bit-1] = tx;
          end else if (tx !== m_lvl) begin
            m_bad = 1'b1;
          end
        end else begin
          if (tx !== 1'b1) m_bad = 1'b1;
        end
        m_i++;
        if (m_i == 10 * bit_clks) begin
          m_active = 0;
          frames_done++;
          chk("frame_shape", {31'd0, m_bad}, 32'd0);
          chk("frame_expected", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            m_exp = sb.pop_front();
            chk("frame_byte", {24'd0, m_byte}, {24'd0, m_exp});
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] d);
    @(posedge clk);
    #1;
    port_id = addr;
    data_in = d;
    write_strobe = 1'b1;
    @(posedge clk);
    #1;
    write_strobe = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] d);
    @(posedge clk);
    #1;
    port_id = addr;
    @(posedge clk);
    #1;
    d = data_out;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(addr, d);
    chk(tag, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_accept);
    if (expect_accept) sb.push_back(b);
    bus_write(BASE + 8'd0, b);
  endtask

  task automatic wait_frames(input int n, input int limit);
    int c;
    c = 0;
    while (frames_done < n && c < limit) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("frame_wait", {31'd0, frames_done >= n}, 32'd1);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    port_id = 8'h00;
    data_in = 8'h00;
    read_strobe = 1'b0;
    write_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", {24'd0, data_out}, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, interrupt}, 32'd0);
    reset = 1'b0;

    // Reset register values
    read_chk("rst_status", BASE + 8'd1, 8'h01);
    read_chk("rst_div_lo", BASE + 8'd3, 8'hB1);
    read_chk("rst_div_hi", BASE + 8'd4, 8'h01);
    read_chk("rst_ctrl", BASE + 8'd2, 8'h00);
    read_chk("rd_txdata", BASE + 8'd0, 8'h00);

    // Single frame at 4 clocks per bit
    bus_write(BASE + 8'd3, 8'd3);
    bus_write(BASE + 8'd4, 8'd0);
    bit_clks = 4;
    read_chk("div_lo_rb", BASE + 8'd3, 8'h03);
    bus_write(BASE + 8'd2, 8'h01);
    read_chk("ctrl_rb", BASE + 8'd2, 8'h01);
    push_byte(8'hA5, 1'b1);
    wait_frames(1, 200);
    read_chk("status_done", BASE + 8'd1, 8'h11);

    // Back-to-back frames at 1 clock per bit
    bus_write(BASE + 8'd2, 8'h00);
    bus_write(BASE + 8'd3, 8'd0);
    bit_clks = 1;
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    push_byte(8'h55, 1'b1);
    base = frames_done;
    bus_write(BASE + 8'd2, 8'h01);
    @(posedge clk);
    #1;
    port_id = BASE + 8'd1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("b2b_busy", {31'd0, data_out[2]}, 32'd1);
      chk("b2b_done_early", {31'd0, data_out[4]}, 32'd0);
    end
    wait_frames(base + 3, 200);
    if (frame_start.size() >= base + 3) begin
      chk("b2b_gap1", frame_start[base+1] - frame_start[base], 32'd10);
      chk("b2b_gap2", frame_start[base+2] - frame_start[base+1], 32'd10);
    end else begin
      chk("b2b_starts", frame_start.size(), base + 3);
    end
    read_chk("b2b_status", BASE + 8'd1, 8'h11);

    // Overflow with TX disabled
    bus_write(BASE + 8'd2, 8'h00);
    for (int k = 0; k < 9; k++) begin
      push_byte(8'h30 + 8'(k), k < 8);
    end
    read_chk("ovf_status", BASE + 8'd1, 8'h0A);
    bus_write(BASE + 8'd1, 8'h08);
    read_chk("ovf_clear", BASE + 8'd1, 8'h02);
    base = frames_done;
    bus_write(BASE + 8'd2, 8'h01);
    wait_frames(base + 8, 500);
    repeat (40) @(posedge clk);
    #1;
    chk("ovf_no_ninth", frames_done, base + 8);
    chk("ovf_sb_empty", sb.size(), 32'd0);
    read_chk("ovf_status_end", BASE + 8'd1, 8'h11);

    // Interrupt
    bus_write(BASE + 8'd2, 8'h03);
    push_byte(8'h96, 1'b1);
    chk("irq_cleared_by_push", {31'd0, interrupt}, 32'd0);
    base = frames_done;
    wait_frames(base + 1, 200);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_rise", {31'd0, interrupt}, 32'd1);
    bus_write(BASE + 8'd1, 8'h10);
    chk("irq_fall", {31'd0, interrupt}, 32'd0);
    read_chk("out_of_range_hi", BASE + 8'd5, 8'h00);
    read_chk("out_of_range_lo", BASE - 8'd1, 8'h00);

    // Reset during data bit 4
    bus_write(BASE + 8'd3, 8'd3);
    bit_clks = 4;
    push_byte(8'h3C, 1'b1);
    push_byte(8'hC3, 1'b1);
    repeat (22) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    sb.delete();
    bit_clks = 434;
    read_chk("midrst_status", BASE + 8'd1, 8'h01);
    read_chk("midrst_ctrl", BASE + 8'd2, 8'h00);
    base = frames_done;
    repeat (100) @(posedge clk);
    #1;
    chk("midrst_no_frames", frames_done, base);
    chk("midrst_tx_idle", {31'd0, tx}, 32'd1);
    chk("midrst_irq", {31'd0, interrupt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pb_uart_tx.md
Name: pb_uart_tx

Overview:
Transmit-only UART peripheral on the Picoblaze port bus (port_id / out_port / strobes). It is a sibling of pb_gpio and consumes CPU OUTPUT writes. Its data_out is ORed into the CPU in_port, alongside the GPIO data_out buses. It buffers bytes in a small FIFO and serialises them as 8N1, LSB first, at a programmable bit period.

Parameters:
BASE_ADDRESS, 8'h10, first of 5 consecutive port addresses decoded by this block
FIFO_DEPTH, 8, TX FIFO entries (power of 2)
FIFO_AW, 3, log2(FIFO_DEPTH)
DEFAULT_DIV, 16'd433, reset value of baud divider (50 MHz / 115200 - 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
port_id  input  8  CPU port address
data_in  input  8  CPU out_port
read_strobe  input  1  CPU read strobe
write_strobe  input  1  CPU write strobe
data_out  output  8  read data; 0 when not addressed (OR-mux into in_port)
interrupt  output  1  level interrupt, transmit-complete
tx  output  1  serial line, idle high

Behaviour:
- One clock. Reset is synchronous and active-high; all state is in the clk domain.
- Register map at BASE_ADDRESS + offset:
  - +0 TXDATA: write pushes a byte; read returns 0.
  - +1 STATUS, read: b0 fifo_empty, b1 fifo_full, b2 busy, b3 overflow, b4 done; b7:5 = 0. STATUS write: b3=1 clears overflow, b4=1 clears done.
  - +2 CONTROL, R/W: b0 tx_enable, b1 irq_enable; other bits read 0.
  - +3 DIV_LO, R/W. +4 DIV_HI, R/W.
- Reset values: tx=1, data_out=0, interrupt=0, FIFO empty, overflow=0, done=0, CONTROL=0, DIV=DEFAULT_DIV, FSM=IDLE.
- Read path:
  - data_out is registered and decoded from port_id alone every cycle, giving 1-cycle latency. KCPSM6 holds port_id for 2 cycles, so in_port is valid when read_strobe samples it.
  - data_out = 0 for any port_id outside the block's address range.
- Writes act in the cycle write_strobe=1 with a matching port_id.
- FIFO push and overflow:
  - A TXDATA write with the FIFO not full is accepted.
  - If the FIFO is full but a pop occurs in the same cycle, the write is also accepted and the count is unchanged.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - A TXDATA write also clears done.
- Bit period = DIV+1 clocks. DIV=0 gives 1 clock per bit.
  - The baud counter reloads from DIV at every bit boundary, so a DIV change takes effect from the next bit.
- FSM:
  - IDLE: tx=1. If tx_enable and FIFO not empty: pop the head into the shift register and go to START. busy=0 only in IDLE.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for one bit period, shift right; after bit index 7, go to STOP.
  - STOP: tx=1 for one bit period. Then, if tx_enable and FIFO not empty, pop and go to START (back-to-back, no idle gap). Otherwise go to IDLE; if the FIFO is empty, set done.
- Pop cadence: the first byte is popped on the IDLE->START edge, so the start bit begins on the following clock. Each frame is exactly 10 bit periods.
- Clearing tx_enable mid-frame completes the current frame, then the FSM holds in IDLE. FIFO contents are retained.
- interrupt = irq_enable & done (level). It is cleared by a STATUS write with b4=1, by a TXDATA write, or by clearing irq_enable.
- Simultaneous STOP-end set and STATUS clear of done: the set wins.
- Reset mid-frame: tx returns to 1 on the next edge and FIFO contents are discarded.
- read_strobe: reserved for read side effects; none are defined, and no register changes on read.

Decomposition:
- pb_uart_tx_defines.vh: register offsets (TXDATA, STATUS, CONTROL, DIV_LO, DIV_HI), STATUS/CONTROL bit positions, FSM state encodings (IDLE, START, DATA, STOP).
- Sub-module pb_sync_fifo: parameterised (WIDTH, DEPTH, AW) single-clock FIFO with push, pop, dout, empty, full; fall-through head. It is reusable by a later pb_uart_rx.

Test Plan:
1. Reset; read BASE+1, BASE+3, BASE+4 -> 8'h01, 8'hB1, 8'h01; tx=1; interrupt=0.
2. DIV=3, CONTROL=8'h01, write 8'hA5 -> tx low for 4 clks, then bits 1,0,1,0,0,1,0,1 (4 clks each), stop high 4 clks. STATUS b4=1 after stop; total 40 clks.
3. DIV=0, push 3 bytes 8'h00, 8'hFF, 8'h55, then enable -> 30 contiguous clocks of frames, no idle between them. busy=1 throughout; done set only after the third stop bit.
4. tx_enable=0, push 9 bytes -> first 8 accepted, full=1, overflow=1. Write STATUS 8'h08 -> overflow=0. Enable -> 8 frames sent, ninth byte never appears.
5. CONTROL=8'h03, send 1 byte -> interrupt rises after the stop bit. Write STATUS 8'h10 -> interrupt falls next cycle. Read port_id=BASE+5 -> data_out=0.
6. Assert reset during DATA bit 4 -> tx=1 next clk, FIFO empty, CONTROL=0, no further frames.
